// File: rtl/fifo_mc.sv
// Multi-channel synchronous FIFO: chan_p independent queues sharing one write
// port and one read port, with per-channel status, clear and optional empty bypass.
module fifo_mc #(
  parameter int data_width_p   = 32,
  parameter int els_p          = 4,
  parameter int chan_p         = 2,
  parameter int afull_thresh_p = els_p - 1,
  parameter bit bypass_p       = 1'b1,
  localparam int cw = (chan_p > 1) ? $clog2(chan_p) : 1,
  localparam int nw = $clog2(els_p + 1),
  localparam int pw = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                     clk_i,
  input  logic                     nreset_i,
  input  logic                     wr_i,
  input  logic [cw-1:0]            wr_chan_i,
  input  logic [data_width_p-1:0]  wdata_i,
  input  logic                     rd_i,
  input  logic [cw-1:0]            rd_chan_i,
  input  logic [chan_p-1:0]        clr_i,
  output logic [chan_p-1:0]        full_o,
  output logic [chan_p-1:0]        afull_o,
  output logic [chan_p-1:0]        empty_o,
  output logic [chan_p*nw-1:0]     count_o,
  output logic                     rvalid_o,
  output logic [data_width_p-1:0]  rdata_o
);

  logic [data_width_p-1:0] mem_q [chan_p][els_p];

  logic [chan_p-1:0][nw-1:0] cnt_all;
  logic [chan_p-1:0][pw-1:0] wptr_all;
  logic [chan_p-1:0][pw-1:0] rptr_all;

  logic          w_ok, r_ok;
  logic [cw-1:0] w_idx, r_idx;
  logic          same, full_w, empty_r;
  logic          enq, deq;

  // A select can only be out of range when chan_p is not a power of two.
  generate
    if (chan_p == (1 << cw)) begin : g_sel_full
      assign w_ok = 1'b1;
      assign r_ok = 1'b1;
    end else begin : g_sel_part
      assign w_ok = ({1'b0, wr_chan_i} < (cw+1)'(chan_p));
      assign r_ok = ({1'b0, rd_chan_i} < (cw+1)'(chan_p));
    end
  endgenerate

  assign w_idx   = w_ok ? wr_chan_i : '0;
  assign r_idx   = r_ok ? rd_chan_i : '0;
  assign same    = w_ok & r_ok & (wr_chan_i == rd_chan_i);
  assign full_w  = (cnt_all[w_idx] == nw'(els_p));
  assign empty_r = (cnt_all[r_idx] == '0);

  // A same-channel read frees a slot for a write to a full channel.
  assign enq = wr_i & w_ok & ~clr_i[w_idx] & (~full_w | (rd_i & same));
  assign deq = rd_i & r_ok & ~clr_i[r_idx] & (~empty_r | (bypass_p & wr_i & same));

  always_comb begin
    rdata_o  = '0;
    rvalid_o = 1'b0;
    if (r_ok && !empty_r) begin
      rdata_o  = mem_q[r_idx][rptr_all[r_idx]];
      rvalid_o = rd_i & ~clr_i[r_idx];
    end else if (bypass_p && wr_i && same && !clr_i[r_idx]) begin
      rdata_o  = wdata_i;
      rvalid_o = rd_i;
    end
  end

  // On bypass the slot is still written; both pointers advance past it.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      mem_q[w_idx][wptr_all[w_idx]] <= wdata_i;
    end
  end

  generate
    for (genvar gi = 0; gi < chan_p; gi++) begin : g_chan
      logic          enq_c, deq_c;
      logic [nw-1:0] cnt_q, cnt_d;
      logic [pw-1:0] wptr_q, wptr_d, rptr_q, rptr_d;

      assign enq_c = enq & (w_idx == cw'(gi));
      assign deq_c = deq & (r_idx == cw'(gi));

      always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (enq_c) begin
          wptr_d = (wptr_q == pw'(els_p - 1)) ? '0 : wptr_q + pw'(1);
        end
        if (deq_c) begin
          rptr_d = (rptr_q == pw'(els_p - 1)) ? '0 : rptr_q + pw'(1);
        end
        if (enq_c && !deq_c) begin
          cnt_d = cnt_q + nw'(1);
        end else if (deq_c && !enq_c) begin
          cnt_d = cnt_q - nw'(1);
        end
      end

      always_ff @(posedge clk_i) begin
        if (!nreset_i || clr_i[gi]) begin
          wptr_q <= '0;
          rptr_q <= '0;
          cnt_q  <= '0;
        end else begin
          wptr_q <= wptr_d;
          rptr_q <= rptr_d;
          cnt_q  <= cnt_d;
        end
      end

      assign cnt_all[gi]            = cnt_q;
      assign wptr_all[gi]           = wptr_q;
      assign rptr_all[gi]           = rptr_q;
      assign full_o[gi]             = (cnt_q == nw'(els_p));
      assign afull_o[gi]            = (cnt_q >= nw'(afull_thresh_p));
      assign empty_o[gi]            = (cnt_q == '0);
      assign count_o[gi*nw +: nw]   = cnt_q;
    end
  endgenerate

  a_wr_chan_range: assert property (@(posedge clk_i) disable iff (!nreset_i) !(wr_i && !w_ok));
  a_rd_chan_range: assert property (@(posedge clk_i) disable iff (!nreset_i) !(rd_i && !r_ok));

endmodule
